exp_job_sequencer: RTL and testbench
====================================

Name: exp_job_sequencer

Overview:
Sequences a single exponentiation core through complete jobs. For each job it resets the core, selects exponentiation or Montgomery-multiply mode, and holds start until done. It then captures the result, bounds runtime with a timeout and presents the result over a valid/ready handshake. It sits between the RSA command FSM (job source) and the exponentiation core, and replaces ad-hoc start/reset driving in the wrapper.

Parameters:
DATA_W, 512, core result width in bits
TAG_W, 4, width of opaque job tag returned with the result
RST_CYCLES, 2, cycles core_resetn is held low after job accept (min 1)
TIMEOUT, 65536, max cycles in RUN before the job is aborted with error (min 2)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
job_valid  in  1  job request
job_ready  out  1  sequencer can accept a job
job_mode  in  1  0 = exponentiation, 1 = Montgomery multiply only
job_tag  in  TAG_W  tag echoed on result
abort  in  1  cancel current job (no result produced)
core_resetn  out  1  core reset, active-low
core_start  out  1  core start level
core_mul_en  out  1  core multiplication_enable
core_done  in  1  core completion
core_result  in  DATA_W  core result, valid while core_done high
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  DATA_W  captured result (0 on error)
res_tag  out  TAG_W  tag of the finished job
res_error  out  1  job ended by timeout
busy  out  1  high in any state other than IDLE
stat_cycles  out  32  RUN cycle count of the last completed or timed-out job

Behaviour:
- All outputs registered. Reset (resetn=0 at edge) forces state IDLE. Output values during reset: job_ready 0, core_resetn 0, core_start 0, core_mul_en 0, res_valid 0, res_data 0, res_tag 0, res_error 0, busy 0, stat_cycles 0.
- job_ready rises on the first edge after resetn returns high.
- States: IDLE, CORE_RST, RUN, OUT.
- IDLE: job_ready=1, core_resetn=0, core_start=0. Accept on an edge with job_valid&&job_ready:
  - latch mode into core_mul_en, latch tag;
  - job_ready->0, busy->1, rst counter->0;
  - go to CORE_RST.
- CORE_RST: core_resetn stays 0 for exactly RST_CYCLES cycles; core_mul_en is already stable. On the last cycle, go to RUN and set core_resetn=1 and core_start=1 on the same edge.
- RUN: core_start held 1. The run counter starts at 0 and increments each cycle.
  - On an edge with core_done=1: res_data<=core_result, res_tag<=tag, res_error<=0, stat_cycles<=counter+1, res_valid<=1, core_start<=0, go to OUT.
  - Else if counter==TIMEOUT-1: res_data<=0, res_error<=1, stat_cycles<=TIMEOUT, res_valid<=1, core_start<=0, go to OUT.
  - core_done and timeout on the same edge: done wins.
- OUT: core_resetn stays 1 and the core is idle. res_valid and res_data/tag/error are held stable until res_valid&&res_ready at an edge. On that edge: res_valid->0, core_resetn->0, core_mul_en->0, busy->0, job_ready->1, go to IDLE.
- A new job cannot be accepted in the same cycle the result is consumed; there is a minimum one IDLE cycle between jobs.
- core_done is ignored outside RUN. A stale done in CORE_RST has no effect.
- abort=1 at an edge in CORE_RST or RUN:
  - go to IDLE with core_start->0, core_resetn->0, job_ready->1, busy->0;
  - no result is produced and res_* and stat_cycles are unchanged.
- abort is ignored in IDLE and OUT. An abort in the same edge as done or timeout takes priority: no result is produced.
- Latency: with done sampled at RUN edge k, res_valid is high starting the cycle after edge k. Accept-to-core_start = RST_CYCLES+1 edges.
- The run counter is wide enough for TIMEOUT; stat_cycles saturates at 2^32-1.

Test Plan:
- Reset release: resetn low 3 cycles, then high -> during reset all outputs 0; job_ready=1 one edge after release; busy=0.
- Normal exp job (RST_CYCLES=2, TIMEOUT=1000): accept mode=0, tag=5; core_done pulses with result 0xDEADBEEF after 40 RUN cycles.
  - Expected: core_resetn low 2 cycles, then core_start=1 and core_mul_en=0.
  - Expected: res_valid the next cycle with res_data=0xDEADBEEF, res_tag=5, res_error=0, stat_cycles=40.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid -> res_* stable, job_ready=0. Raise res_ready -> IDLE, job_ready=1 one cycle later, and a new job_valid is accepted only then.
- Mont job with timeout: mode=1, TIMEOUT=1000, core_done never asserted -> core_mul_en=1 throughout; after 1000 RUN cycles res_valid=1, res_error=1, res_data=0, stat_cycles=1000.
- Abort: assert abort at RUN cycle 7 -> next cycle core_start=0, core_resetn=0, job_ready=1; no res_valid; stat_cycles keeps its previous value (40).
- Races and glitches:
  - core_done at the same edge as timeout -> res_error=0 and result captured.
  - core_done glitch during CORE_RST -> ignored; the job completes on a later done.
  - resetn low mid-RUN -> all outputs at reset values next edge.

Source files
------------

// File: rtl/exp_job_sequencer_if.sv
// Job-source, core and result signals of the exponentiation job sequencer.
// The slave modport is the sequencer; master is the surrounding system.
interface exp_job_sequencer_if #(
  parameter int DATA_W = 512,
  parameter int TAG_W  = 4
);
  logic              job_valid;
  logic              job_ready;
  logic              job_mode;
  logic [TAG_W-1:0]  job_tag;
  logic              abort;
  logic              core_resetn;
  logic              core_start;
  logic              core_mul_en;
  logic              core_done;
  logic [DATA_W-1:0] core_result;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [TAG_W-1:0]  res_tag;
  logic              res_error;
  logic              busy;
  logic [31:0]       stat_cycles;

  modport master (
    output job_valid, job_mode, job_tag, abort, core_done, core_result, res_ready,
    input  job_ready, core_resetn, core_start, core_mul_en,
           res_valid, res_data, res_tag, res_error, busy, stat_cycles
  );

  modport slave (
    input  job_valid, job_mode, job_tag, abort, core_done, core_result, res_ready,
    output job_ready, core_resetn, core_start, core_mul_en,
           res_valid, res_data, res_tag, res_error, busy, stat_cycles
  );
endinterface

// File: rtl/exp_job_sequencer.sv
// Drives one exponentiation core through reset/start/done per job, with
// timeout, abort and a registered valid/ready result port.
module exp_job_sequencer #(
  parameter int DATA_W     = 512,
  parameter int TAG_W      = 4,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 65536
) (
  input  logic               clk,
  input  logic               resetn,
  exp_job_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CORE_RST, S_RUN, S_OUT} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int SW    = (CNT_W > 32) ? CNT_W + 1 : 33;

  state_t            r_state, w_state;
  logic              r_job_ready, w_job_ready;
  logic              r_core_resetn, w_core_resetn;
  logic              r_core_start, w_core_start;
  logic              r_mul_en, w_mul_en;
  logic [TAG_W-1:0]  r_tag, w_tag;
  logic              r_res_valid, w_res_valid;
  logic [DATA_W-1:0] r_res_data, w_res_data;
  logic [TAG_W-1:0]  r_res_tag, w_res_tag;
  logic              r_res_error, w_res_error;
  logic              r_busy, w_busy;
  logic [31:0]       r_stat, w_stat;
  logic [RST_W-1:0]  r_rst_cnt, w_rst_cnt;
  logic [CNT_W-1:0]  r_run_cnt, w_run_cnt;
  logic [SW-1:0]     w_cnt_p1;
  logic [31:0]       w_stat_sat;

  // Run length including the current edge, saturated to 32 bits.
  assign w_cnt_p1   = SW'(r_run_cnt) + SW'(1);
  assign w_stat_sat = (w_cnt_p1 > SW'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : w_cnt_p1[31:0];

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state;
  end

  always_comb begin
    w_state       = r_state;
    w_job_ready   = r_job_ready;
    w_core_resetn = r_core_resetn;
    w_core_start  = r_core_start;
    w_mul_en      = r_mul_en;
    w_tag         = r_tag;
    w_res_valid   = r_res_valid;
    w_res_data    = r_res_data;
    w_res_tag     = r_res_tag;
    w_res_error   = r_res_error;
    w_busy        = r_busy;
    w_stat        = r_stat;
    w_rst_cnt     = r_rst_cnt;
    w_run_cnt     = r_run_cnt;
    case (r_state)
      S_IDLE: begin
        w_job_ready   = 1'b1;
        w_core_resetn = 1'b0;
        w_core_start  = 1'b0;
        w_busy        = 1'b0;
        if (bus.job_valid && r_job_ready) begin
          w_mul_en    = bus.job_mode;
          w_tag       = bus.job_tag;
          w_job_ready = 1'b0;
          w_busy      = 1'b1;
          w_rst_cnt   = '0;
          w_state     = S_CORE_RST;
        end
      end
      S_CORE_RST, S_RUN: begin
        if (bus.abort) begin
          // Abort outranks done/timeout: the job vanishes without a result.
          w_state       = S_IDLE;
          w_core_start  = 1'b0;
          w_core_resetn = 1'b0;
          w_mul_en      = 1'b0;
          w_job_ready   = 1'b1;
          w_busy        = 1'b0;
        end else if (r_state == S_CORE_RST) begin
          if (r_rst_cnt == RST_W'(RST_CYCLES - 1)) begin
            w_state       = S_RUN;
            w_core_resetn = 1'b1;
            w_core_start  = 1'b1;
            w_run_cnt     = '0;
          end else begin
            w_rst_cnt = r_rst_cnt + RST_W'(1);
          end
        end else if (bus.core_done || r_run_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_res_data   = bus.core_done ? bus.core_result : '0;
          w_res_error  = !bus.core_done;
          w_res_tag    = r_tag;
          w_stat       = w_stat_sat;
          w_res_valid  = 1'b1;
          w_core_start = 1'b0;
          w_state      = S_OUT;
        end else begin
          w_run_cnt = r_run_cnt + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (r_res_valid && bus.res_ready) begin
          w_res_valid   = 1'b0;
          w_core_resetn = 1'b0;
          w_mul_en      = 1'b0;
          w_busy        = 1'b0;
          w_job_ready   = 1'b1;
          w_state       = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_job_ready   <= 1'b0;
      r_core_resetn <= 1'b0;
      r_core_start  <= 1'b0;
      r_mul_en      <= 1'b0;
      r_tag         <= '0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_tag     <= '0;
      r_res_error   <= 1'b0;
      r_busy        <= 1'b0;
      r_stat        <= '0;
      r_rst_cnt     <= '0;
      r_run_cnt     <= '0;
    end else begin
      r_job_ready   <= w_job_ready;
      r_core_resetn <= w_core_resetn;
      r_core_start  <= w_core_start;
      r_mul_en      <= w_mul_en;
      r_tag         <= w_tag;
      r_res_valid   <= w_res_valid;
      r_res_data    <= w_res_data;
      r_res_tag     <= w_res_tag;
      r_res_error   <= w_res_error;
      r_busy        <= w_busy;
      r_stat        <= w_stat;
      r_rst_cnt     <= w_rst_cnt;
      r_run_cnt     <= w_run_cnt;
    end
  end

  assign bus.job_ready   = r_job_ready;
  assign bus.core_resetn = r_core_resetn;
  assign bus.core_start  = r_core_start;
  assign bus.core_mul_en = r_mul_en;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_data    = r_res_data;
  assign bus.res_tag     = r_res_tag;
  assign bus.res_error   = r_res_error;
  assign bus.busy        = r_busy;
  assign bus.stat_cycles = r_stat;
endmodule

// File: tb/tb_exp_job_sequencer.sv
// Directed bench for exp_job_sequencer: reset, exp/mont jobs, backpressure,
// abort, timeout, done/timeout race, CORE_RST glitch and mid-run reset.
module tb_exp_job_sequencer;
  localparam int DATA_W     = 32;
  localparam int TAG_W      = 4;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 1000;

  logic clk = 1'b0;
  logic resetn;
  int   nchecks = 0;
  int   nerrors = 0;

  exp_job_sequencer_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  exp_job_sequencer #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " job_ready"},   64'(bus.job_ready),   0);
    check({tag, " core_resetn"}, 64'(bus.core_resetn), 0);
    check({tag, " core_start"},  64'(bus.core_start),  0);
    check({tag, " core_mul_en"}, 64'(bus.core_mul_en), 0);
    check({tag, " res_valid"},   64'(bus.res_valid),   0);
    check({tag, " res_data"},    64'(bus.res_data),    0);
    check({tag, " res_tag"},     64'(bus.res_tag),     0);
    check({tag, " res_error"},   64'(bus.res_error),   0);
    check({tag, " busy"},        64'(bus.busy),        0);
    check({tag, " stat_cycles"}, 64'(bus.stat_cycles), 0);
  endtask

  // Present a job while idle and take the accepting edge.
  task automatic accept(input logic mode, input logic [TAG_W-1:0] tag);
    bus.job_valid = 1'b1; bus.job_mode = mode; bus.job_tag = tag;
    step();
    bus.job_valid = 1'b0;
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    bus.job_valid = 0; bus.job_mode = 0; bus.job_tag = 0; bus.abort = 0;
    bus.core_done = 0; bus.core_result = 0; bus.res_ready = 0;

    // Reset and release
    step(3);
    check_all_zero("reset");
    resetn = 1'b1;
    step();
    check("release job_ready", 64'(bus.job_ready), 1);
    check("release busy",      64'(bus.busy),      0);

    // Normal exponentiation job
    accept(1'b0, 4'd5);
    check("exp accept job_ready", 64'(bus.job_ready),   0);
    check("exp accept busy",      64'(bus.busy),        1);
    check("exp rst0 core_resetn", 64'(bus.core_resetn), 0);
    check("exp rst0 core_start",  64'(bus.core_start),  0);
    check("exp mul_en",           64'(bus.core_mul_en), 0);
    step();
    check("exp rst1 core_resetn", 64'(bus.core_resetn), 0);
    check("exp rst1 core_start",  64'(bus.core_start),  0);
    step();
    check("exp run core_resetn",  64'(bus.core_resetn), 1);
    check("exp run core_start",   64'(bus.core_start),  1);
    check("exp run mul_en",       64'(bus.core_mul_en), 0);
    step(39);
    check("exp pre-done start",   64'(bus.core_start),  1);
    check("exp pre-done valid",   64'(bus.res_valid),   0);
    bus.core_done = 1'b1; bus.core_result = 32'hDEADBEEF;
    step();
    bus.core_done = 1'b0; bus.core_result = 0;
    check("exp res_valid",   64'(bus.res_valid),   1);
    check("exp res_data",    64'(bus.res_data),    64'hDEADBEEF);
    check("exp res_tag",     64'(bus.res_tag),     5);
    check("exp res_error",   64'(bus.res_error),   0);
    check("exp stat_cycles", 64'(bus.stat_cycles), 40);
    check("exp done start",  64'(bus.core_start),  0);

    // Backpressure, with a job already offered during OUT
    bus.job_valid = 1'b1; bus.job_mode = 1'b0; bus.job_tag = 4'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp res_valid", 64'(bus.res_valid), 1);
      check("bp res_data",  64'(bus.res_data),  64'hDEADBEEF);
      check("bp job_ready", 64'(bus.job_ready), 0);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("consume res_valid",   64'(bus.res_valid),   0);
    check("consume job_ready",   64'(bus.job_ready),   1);
    check("consume busy",        64'(bus.busy),        0);
    check("consume core_resetn", 64'(bus.core_resetn), 0);
    step();
    bus.job_valid = 1'b0;
    check("next accept job_ready", 64'(bus.job_ready), 0);
    check("next accept busy",      64'(bus.busy),      1);

    // Abort at RUN cycle 7, with done on the same edge
    step(2);
    check("abort run start", 64'(bus.core_start), 1);
    step(6);
    bus.abort = 1'b1; bus.core_done = 1'b1; bus.core_result = 32'h11111111;
    step();
    bus.abort = 1'b0; bus.core_done = 1'b0;
    check("abort core_start",  64'(bus.core_start),  0);
    check("abort core_resetn", 64'(bus.core_resetn), 0);
    check("abort job_ready",   64'(bus.job_ready),   1);
    check("abort busy",        64'(bus.busy),        0);
    check("abort res_valid",   64'(bus.res_valid),   0);
    check("abort stat",        64'(bus.stat_cycles), 40);
    check("abort res_data",    64'(bus.res_data),    64'hDEADBEEF);
    step();
    check("abort later valid", 64'(bus.res_valid),   0);

    // Montgomery job that times out
    accept(1'b1, 4'd9);
    check("mont mul_en rst", 64'(bus.core_mul_en), 1);
    step(2);
    step(999);
    check("mont pre-timeout valid",  64'(bus.res_valid),   0);
    check("mont pre-timeout mul_en", 64'(bus.core_mul_en), 1);
    step();
    check("mont to res_valid",  64'(bus.res_valid),   1);
    check("mont to res_error",  64'(bus.res_error),   1);
    check("mont to res_data",   64'(bus.res_data),    0);
    check("mont to stat",       64'(bus.stat_cycles), 1000);
    check("mont to res_tag",    64'(bus.res_tag),     9);
    check("mont to core_start", 64'(bus.core_start),  0);
    consume();

    // core_done on the timeout edge: done wins
    accept(1'b0, 4'd7);
    step(2);
    step(999);
    bus.core_done = 1'b1; bus.core_result = 32'h12345678;
    step();
    bus.core_done = 1'b0;
    check("race res_valid", 64'(bus.res_valid),   1);
    check("race res_error", 64'(bus.res_error),   0);
    check("race res_data",  64'(bus.res_data),    64'h12345678);
    check("race stat",      64'(bus.stat_cycles), 1000);
    consume();

    // Stale done during CORE_RST is ignored
    accept(1'b0, 4'd2);
    bus.core_done = 1'b1; bus.core_result = 32'hBAD0BAD0;
    step();
    bus.core_done = 1'b0;
    check("glitch valid rst",   64'(bus.res_valid),  0);
    step();
    check("glitch valid run",   64'(bus.res_valid),  0);
    check("glitch start run",   64'(bus.core_start), 1);
    step(3);
    bus.core_done = 1'b1; bus.core_result = 32'hCAFE0001;
    step();
    bus.core_done = 1'b0;
    check("glitch res_valid", 64'(bus.res_valid),   1);
    check("glitch res_data",  64'(bus.res_data),    64'hCAFE0001);
    check("glitch res_tag",   64'(bus.res_tag),     2);
    check("glitch stat",      64'(bus.stat_cycles), 4);
    consume();

    // Reset in the middle of RUN
    accept(1'b1, 4'd1);
    step(2);
    step(5);
    check("midrun busy", 64'(bus.busy), 1);
    resetn = 1'b0;
    step();
    check_all_zero("midrun reset");
    resetn = 1'b1;
    step();
    check("midrun release job_ready", 64'(bus.job_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
